// File: rtl/pipe_ctrl_pkg.sv
// Pipeline control types: FSM states and the hold/flush control bundles.
// Shared by the hazard controller and its flop primitive.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic hold_pc;
    logic hold_ifid;
    logic hold_idex;
    logic hold_exmem;
    logic flush_ifid;
    logic flush_idex;
    logic flush_exmem;
    logic pc_jump;
  } ctl_t;

  localparam ctl_t CTL_NONE = 8'b0000_000_0;
  localparam ctl_t CTL_MEM  = 8'b1111_000_0;
  localparam ctl_t CTL_DIV  = 8'b1110_001_0;
  localparam ctl_t CTL_JUMP = 8'b0000_110_1;
  localparam ctl_t CTL_LU   = 8'b1100_010_0;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // x0 is hardwired zero, so it can never be a load-use source
  function automatic logic reg_hit(
    input logic       ren,
    input logic [4:0] rs,
    input logic [4:0] rd
  );
    return ren && (rs == rd) && (rd != 5'd0);
  endfunction

endpackage

// File: rtl/pipe_ctrl_gnrl_dff.sv
// Generic enabled flop with synchronous active-high reset.
// Reset wins over enable.
module gnrl_dff #(
  parameter int          W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= RST_VAL;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory/divide stalls, jump redirect,
// load-use interlock and a saturating stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_raddr,
  input  logic [4:0]  id_rs2_raddr,
  input  logic        id_rs1_ren,
  input  logic        id_rs2_ren,
  input  logic [4:0]  ex_rd_waddr,
  input  logic        ex_is_load,
  input  logic        ex_jump,
  input  logic [31:0] ex_jump_addr,
  input  logic        ex_div_start,
  input  logic        div_done,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        hold_pc,
  output logic        hold_ifid,
  output logic        hold_idex,
  output logic        hold_exmem,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        flush_exmem,
  output logic        pc_jump,
  output logic [31:0] pc_jump_addr,
  output logic [31:0] stall_cnt
);

  logic [1:0] state_raw;
  state_e     state_q;
  state_e     state_d;
  ctl_t       ctl;

  logic mem_stall, mem_hold, div_hold, lu_hit;
  logic is_mem, is_div, is_jmp, is_lu;

  assign state_q = state_e'(state_raw);

  gnrl_dff #(.W(2), .RST_VAL(2'(ST_RUN))) u_state (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (state_d),
    .q   (state_raw)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (mem_stall)
          state_d = ST_MEM_WAIT;
        else if (ex_div_start)
          state_d = ST_DIV_WAIT;
      end
      ST_DIV_WAIT: if (div_done) state_d = ST_RUN;
      ST_MEM_WAIT: if (mem_ack)  state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  assign mem_stall = mem_req & ~mem_ack;
  assign mem_hold  = mem_stall |
                     ((state_q == ST_MEM_WAIT) & ~mem_ack);
  assign div_hold  = ((state_q == ST_RUN) & ex_div_start) |
                     ((state_q == ST_DIV_WAIT) & ~div_done);
  assign lu_hit    = ex_is_load &
                     (reg_hit(id_rs1_ren, id_rs1_raddr, ex_rd_waddr) |
                      reg_hit(id_rs2_ren, id_rs2_raddr, ex_rd_waddr));

  // Mutually exclusive selects in priority order
  assign is_mem = ~rst & mem_hold;
  assign is_div = ~rst & ~mem_hold & div_hold;
  assign is_jmp = ~rst & ~mem_hold & ~div_hold & ex_jump;
  assign is_lu  = ~rst & ~mem_hold & ~div_hold & ~ex_jump & lu_hit;

  always_comb begin
    ctl = CTL_NONE;
    unique case (1'b1)
      is_mem:  ctl = CTL_MEM;
      is_div:  ctl = CTL_DIV;
      is_jmp:  ctl = CTL_JUMP;
      is_lu:   ctl = CTL_LU;
      default: ctl = CTL_NONE;
    endcase
  end

  assign hold_pc      = ctl.hold_pc;
  assign hold_ifid    = ctl.hold_ifid;
  assign hold_idex    = ctl.hold_idex;
  assign hold_exmem   = ctl.hold_exmem;
  assign flush_ifid   = ctl.flush_ifid;
  assign flush_idex   = ctl.flush_idex;
  assign flush_exmem  = ctl.flush_exmem;
  assign pc_jump      = ctl.pc_jump;
  assign pc_jump_addr = ctl.pc_jump ? ex_jump_addr : 32'd0;

  gnrl_dff #(.W(32), .RST_VAL(32'd0)) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (hold_pc & (stall_cnt != CNT_MAX)),
    .d   (stall_cnt + 32'd1),
    .q   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with a queue scoreboard.
// Expected outputs are queued per cycle and checked by a monitor.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_raddr, id_rs2_raddr, ex_rd_waddr;
  logic        id_rs1_ren, id_rs2_ren, ex_is_load;
  logic        ex_jump, ex_div_start, div_done;
  logic [31:0] ex_jump_addr;
  logic        mem_req, mem_ack;
  logic        hold_pc, hold_ifid, hold_idex, hold_exmem;
  logic        flush_ifid, flush_idex, flush_exmem, pc_jump;
  logic [31:0] pc_jump_addr, stall_cnt;

  logic [71:0] exp_q[$];
  string       name_q[$];
  logic [31:0] exp_cnt;
  int          n_vec = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1_raddr (id_rs1_raddr),
    .id_rs2_raddr (id_rs2_raddr),
    .id_rs1_ren   (id_rs1_ren),
    .id_rs2_ren   (id_rs2_ren),
    .ex_rd_waddr  (ex_rd_waddr),
    .ex_is_load   (ex_is_load),
    .ex_jump      (ex_jump),
    .ex_jump_addr (ex_jump_addr),
    .ex_div_start (ex_div_start),
    .div_done     (div_done),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .hold_pc      (hold_pc),
    .hold_ifid    (hold_ifid),
    .hold_idex    (hold_idex),
    .hold_exmem   (hold_exmem),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .flush_exmem  (flush_exmem),
    .pc_jump      (pc_jump),
    .pc_jump_addr (pc_jump_addr),
    .stall_cnt    (stall_cnt)
  );

  // Monitor: outputs are valid every cycle, checked mid-cycle
  always @(negedge clk) begin
    logic [71:0] act, e;
    string       nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act = {hold_pc, hold_ifid, hold_idex, hold_exmem,
             flush_ifid, flush_idex, flush_exmem, pc_jump,
             pc_jump_addr, stall_cnt};
      n_vec++;
      if (act !== e) begin
        n_miss++;
        $display("FAIL %s: got hold=%b flush=%b pj=%b addr=%h cnt=%h want hold=%b flush=%b pj=%b addr=%h cnt=%h",
                 nm, act[71:68], act[67:65], act[64], act[63:32], act[31:0],
                 e[71:68], e[67:65], e[64], e[63:32], e[31:0]);
      end
    end
  end

  task automatic idle();
    rst = 1'b0;
    id_rs1_raddr = 5'd0; id_rs2_raddr = 5'd0;
    id_rs1_ren = 1'b0;   id_rs2_ren = 1'b0;
    ex_rd_waddr = 5'd0;  ex_is_load = 1'b0;
    ex_jump = 1'b0;      ex_jump_addr = 32'd0;
    ex_div_start = 1'b0; div_done = 1'b0;
    mem_req = 1'b0;      mem_ack = 1'b0;
  endtask

  // One cycle: queue expectation, advance, update expected counter
  task automatic cyc(input string nm, input logic [3:0] h,
                     input logic [2:0] f, input logic pj,
                     input logic [31:0] pja);
    exp_q.push_back({h, f, pj, pja, exp_cnt});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    if (rst)
      exp_cnt = 32'd0;
    else if (h[3] && exp_cnt != 32'hFFFF_FFFF)
      exp_cnt = exp_cnt + 32'd1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    ex_jump = 1'b1; ex_jump_addr = 32'h40; mem_req = 1'b1;
    exp_cnt = 32'hx;
    @(posedge clk); #1;
    exp_cnt = 32'd0;
    cyc("reset_outputs_zero", 4'b0000, 3'b000, 1'b0, 32'd0);

    idle();
    cyc("idle", 4'b0000, 3'b000, 1'b0, 32'd0);

    ex_is_load = 1'b1; ex_rd_waddr = 5'd5;
    id_rs1_ren = 1'b1; id_rs1_raddr = 5'd5;
    cyc("load_use_rs1", 4'b1100, 3'b010, 1'b0, 32'd0);
    idle();
    cyc("after_load_use", 4'b0000, 3'b000, 1'b0, 32'd0);

    ex_is_load = 1'b1; ex_rd_waddr = 5'd0;
    id_rs1_ren = 1'b1; id_rs1_raddr = 5'd0;
    cyc("load_x0_no_stall", 4'b0000, 3'b000, 1'b0, 32'd0);

    idle();
    ex_is_load = 1'b1; ex_rd_waddr = 5'd9;
    id_rs2_raddr = 5'd9; id_rs2_ren = 1'b0;
    cyc("rs2_match_not_read", 4'b0000, 3'b000, 1'b0, 32'd0);
    id_rs2_ren = 1'b1;
    cyc("load_use_rs2", 4'b1100, 3'b010, 1'b0, 32'd0);

    ex_jump = 1'b1; ex_jump_addr = 32'h0000_0100;
    cyc("jump_over_load_use", 4'b0000, 3'b110, 1'b1, 32'h100);
    idle();
    cyc("after_jump", 4'b0000, 3'b000, 1'b0, 32'd0);

    ex_div_start = 1'b1;
    cyc("div_start", 4'b1110, 3'b001, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++)
      cyc("div_wait", 4'b1110, 3'b001, 1'b0, 32'd0);
    div_done = 1'b1;
    cyc("div_done_release", 4'b0000, 3'b000, 1'b0, 32'd0);
    idle();
    cyc("div_run_cnt11", 4'b0000, 3'b000, 1'b0, 32'd0);

    mem_req = 1'b1; ex_jump = 1'b1; ex_jump_addr = 32'h0000_0200;
    for (int i = 0; i < 3; i++)
      cyc("mem_stall_defer_jump", 4'b1111, 3'b000, 1'b0, 32'd0);
    mem_ack = 1'b1;
    cyc("mem_ack_take_jump", 4'b0000, 3'b110, 1'b1, 32'h200);
    idle();
    cyc("after_mem", 4'b0000, 3'b000, 1'b0, 32'd0);

    ex_div_start = 1'b1;
    cyc("div_start2", 4'b1110, 3'b001, 1'b0, 32'd0);
    cyc("div_wait2", 4'b1110, 3'b001, 1'b0, 32'd0);
    rst = 1'b1;
    cyc("rst_in_div_wait", 4'b0000, 3'b000, 1'b0, 32'd0);
    rst = 1'b0; ex_div_start = 1'b0;
    cyc("run_after_rst", 4'b0000, 3'b000, 1'b0, 32'd0);

    force dut.u_cnt.q = 32'hFFFF_FFFE;
    #1;
    release dut.u_cnt.q;
    exp_cnt = 32'hFFFF_FFFE;
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc("cnt_saturate", 4'b1111, 3'b000, 1'b0, 32'd0);
    mem_ack = 1'b1;
    cyc("cnt_saturated", 4'b0000, 3'b000, 1'b0, 32'd0);
    idle();
    cyc("cnt_still_max", 4'b0000, 3'b000, 1'b0, 32'd0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
